// File: rtl/demorgan_pkg.sv
// Shared types and constants for the demorgan truth-table sweep controller.
// The expected words are the datapath outputs for each {A,B} input vector.
package demorgan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int OBS_NA      = 0;
  localparam int OBS_NB      = 1;
  localparam int OBS_NANDNB  = 2;
  localparam int OBS_AANDB   = 3;
  localparam int OBS_NAB     = 4;
  localparam int OBS_NAORNB  = 5;
  localparam int OBS_AORB    = 6;
  localparam int OBS_NAORB   = 7;

  localparam logic [7:0] EXP_00 = 8'hB7;
  localparam logic [7:0] EXP_01 = 8'h71;
  localparam logic [7:0] EXP_10 = 8'h72;
  localparam logic [7:0] EXP_11 = 8'h48;

  function automatic logic [7:0] exp_obs(input logic a, input logic b);
    logic [7:0] r;
    case ({a, b})
      2'b00:   r = EXP_00;
      2'b01:   r = EXP_01;
      2'b10:   r = EXP_10;
      default: r = EXP_11;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/demorgan_expect.sv
// Combinational expected-output lookup for one {A,B} vector of the demorgan datapath.
module demorgan_expect
  import demorgan_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [7:0] exp_o
);

  assign exp_o = exp_obs(a_i, b_i);

endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// Walks the datapath through all four {A,B} vectors, samples its outputs after a
// settle window and records mismatch count plus the first failing vector and mask.
module demorgan_sweep_ctrl
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] obs,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail_vec,
  output logic [7:0] first_fail_mask
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             pass_q, pass_d;
  logic [2:0]       err_q, err_d;
  logic [1:0]       ffv_q, ffv_d;
  logic [7:0]       ffm_q, ffm_d;

  logic [7:0]       exp_w;
  logic [7:0]       diff_w;

  // Expected word follows the vector counter, which tracks {a_out,b_out} while busy.
  demorgan_expect u_expect (
    .a_i   (vec_q[1]),
    .b_i   (vec_q[0]),
    .exp_o (exp_w)
  );

  assign diff_w = obs ^ exp_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      ffv_q   <= 2'd0;
      ffm_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffm_d   = ffm_q;

    if (abort) begin
      // Partial error results are kept so the host can inspect what was seen so far.
      state_d = ST_IDLE;
      a_d     = 1'b0;
      b_d     = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SETTLE;
            vec_d   = 2'd0;
            cnt_d   = '0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = 1'b0;
            err_d   = 3'd0;
            ffv_d   = 2'd0;
            ffm_d   = 8'd0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          if (diff_w != 8'd0) begin
            err_d = err_q + 3'd1;
            if (err_q == 3'd0) begin
              ffv_d = vec_q;
              ffm_d = diff_w;
            end
          end
          if (vec_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_SETTLE;
            vec_d      = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
            cnt_d      = '0;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          pass_d  = (err_q == 3'd0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign a_out           = a_q;
  assign b_out           = b_q;
  assign busy            = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Directed bench for the demorgan sweep controller: table of fault modes plus
// hand-written abort, restart, reset and long-settle sequences.
module tb_demorgan_sweep_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] obs;
  logic       a_out, b_out, busy, done, pass_w;
  logic [2:0] err_count;
  logic [1:0] ffv;
  logic [7:0] ffm;

  logic       start3;
  logic [7:0] obs3;
  logic       a3, b3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [1:0] ffv3;
  logic [7:0] ffm3;

  int mode;
  int pass_cnt;
  int total_cnt;
  int done_cnt;

  typedef struct {
    int         fmode;
    logic [2:0] err;
    logic [1:0] fvec;
    logic [7:0] fmask;
    logic       pass;
  } vec_t;

  vec_t tbl [4];

  demorgan_sweep_ctrl #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .obs(obs),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass_w),
    .err_count(err_count), .first_fail_vec(ffv), .first_fail_mask(ffm)
  );

  demorgan_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(1'b0), .obs(obs3),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail_vec(ffv3), .first_fail_mask(ffm3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference datapath written from the boolean definitions of each output bit.
  function automatic logic [7:0] bench_exp(input logic a, input logic b);
    return {~(a | b), a | b, ~a | ~b, ~(a & b), a & b, ~a & ~b, ~b, ~a};
  endfunction

  always_comb begin
    obs = bench_exp(a_out, b_out);
    case (mode)
      1: if (a_out && b_out) obs = obs & 8'hF7;
      2: obs = 8'h00;
      3: begin
        if (!a_out && b_out) obs = obs ^ 8'h01;
        if (a_out && !b_out) obs = obs ^ 8'h80;
      end
      default: ;
    endcase
  end

  assign obs3 = bench_exp(a3, b3);

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input int m, input bit walk);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (walk) begin
        check("walk_ab", {a_out, b_out}, c / 2);
        check("walk_busy", busy, 1);
        check("walk_nodone", done, 0);
      end
      tick();
    end
    check("done_pulse", done, 1);
    check("done_notbusy", busy, 0);
    tick();
    check("done_cleared", done, 0);
    $display("sweep mode=%0d err=%0d ffv=%0d ffm=%0h pass=%0d",
             m, err_count, ffv, ffm, pass_w);
  endtask

  initial begin
    int dc;
    int n;
    pass_cnt  = 0;
    total_cnt = 0;
    done_cnt  = 0;
    mode      = 0;
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    start3    = 1'b0;

    tbl[0] = '{0, 3'd0, 2'b00, 8'h00, 1'b1};
    tbl[1] = '{1, 3'd1, 2'b11, 8'h08, 1'b0};
    tbl[2] = '{2, 3'd4, 2'b00, 8'hB7, 1'b0};
    tbl[3] = '{3, 3'd2, 2'b01, 8'h01, 1'b0};

    tick();
    tick();
    check("rst_ab", {a_out, b_out}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_w, 0);
    check("rst_err", err_count, 0);
    check("rst_ffv", ffv, 0);
    check("rst_ffm", ffm, 0);
    reset = 1'b0;
    tick();

    // Good sweep with full per-cycle vector walk.
    run_sweep(0, 1);
    check("good_pass", pass_w, 1);
    check("good_err", err_count, 0);
    check("good_ab_idle", {a_out, b_out}, 0);

    for (int i = 0; i < 4; i++) begin
      run_sweep(tbl[i].fmode, 0);
      check("tbl_err", err_count, tbl[i].err);
      check("tbl_ffv", ffv, tbl[i].fvec);
      check("tbl_ffm", ffm, tbl[i].fmask);
      check("tbl_pass", pass_w, tbl[i].pass);
    end

    // Abort during vector 2 settle, with two failures already recorded.
    run_sweep(0, 0);
    check("pre_abort_pass", pass_w, 1);
    mode  = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_at_vec2", {a_out, b_out}, 2);
    check("abort_busy_before", busy, 1);
    dc    = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_ab", {a_out, b_out}, 0);
    check("abort_busy", busy, 0);
    check("abort_pass", pass_w, 0);
    check("abort_err_hold", err_count, 2);
    check("abort_ffm_hold", ffm, 8'hB7);
    repeat (10) tick();
    check("abort_nodone", done_cnt, dc);
    $display("abort sequence err=%0d busy=%0d", err_count, busy);

    // Start re-pulsed while busy must not restart the sweep.
    mode  = 0;
    dc    = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_ignored_ab", {a_out, b_out}, 1);
    repeat (5) tick();
    check("restart_done_time", done, 1);
    repeat (5) tick();
    check("restart_done_cnt", done_cnt, dc + 1);
    check("restart_pass", pass_w, 1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    repeat (10) tick();
    check("start_abort_nodone", done_cnt, dc + 1);
    check("start_abort_pass", pass_w, 0);
    $display("restart sequence done_cnt=%0d", done_cnt - dc);

    // Asynchronous reset between edges in the middle of a failing sweep.
    mode  = 2;
    dc    = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("pre_reset_err", err_count, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_ab", {a_out, b_out}, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err_count, 0);
    check("arst_ffm", ffm, 0);
    check("arst_pass", pass_w, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("arst_nodone", done_cnt, dc);
    run_sweep(0, 1);
    check("post_reset_pass", pass_w, 1);
    check("post_reset_err", err_count, 0);

    // Long settle window: done expected 16 edges after start is sampled.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 40) begin
      tick();
      n++;
    end
    check("s3_done_latency", n, 16);
    tick();
    check("s3_pass", pass3, 1);
    check("s3_err", err3, 0);
    $display("settle3 sweep done after %0d cycles", n);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
